// File: rtl/key_debouncer_pkg.sv
// key_pkg: state encoding and default timing shared by the key debouncer files.
package key_pkg;
  typedef enum logic [1:0] {REL, WAIT_P, PRS, WAIT_R} key_state_t;
  localparam int KEY_DEBOUNCE_DEFAULT      = 500000;
  localparam int KEY_REPEAT_DELAY_DEFAULT  = 25000000;
  localparam int KEY_REPEAT_PERIOD_DEFAULT = 5000000;
endpackage

// File: rtl/key_debouncer_if.sv
// key_debouncer_if: raw pins in, debounced level and press/release strobes out.
interface key_debouncer_if #(parameter int N_KEYS = 2);
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  modport master (output key_raw, input key_level, key_press, key_release);
  modport slave (input key_raw, output key_level, key_press, key_release);
endinterface

// File: rtl/key_debouncer_chan.sv
// key_debounce_chan: one key's synchroniser, debounce FSM and counter.
// Build with KEY_AUTOREPEAT_EN to re-pulse o_press while the key stays held.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
  parameter int ACTIVE_LOW      = 1
`ifdef KEY_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY  = KEY_REPEAT_DELAY_DEFAULT
  , parameter int REPEAT_PERIOD = KEY_REPEAT_PERIOD_DEFAULT
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] r_sync;
  key_state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic r_level, r_press, r_release;
  logic w_pin, w_sync, w_done, w_level, w_press, w_release, w_rpt_fire;
  assign w_pin  = (ACTIVE_LOW != 0) ? ~i_raw : i_raw;
  assign w_sync = r_sync[1];
  // The entry cycle counts as the first stable one, so the move fires one count early.
  assign w_done = r_cnt == CNT_W'(DEBOUNCE_CYCLES - 2);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_sync    <= '0;
      r_state   <= REL;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], w_pin};
      r_state   <= w_next;
      r_cnt     <= w_cnt_next;
      r_level   <= w_level;
      r_press   <= w_press;
      r_release <= w_release;
    end
  always_comb begin
    w_next     = r_state;
    w_cnt_next = '0;
    case (r_state)
      REL:    w_next = w_sync ? WAIT_P : REL;
      WAIT_P: begin
        w_next     = !w_sync ? REL : w_done ? PRS : WAIT_P;
        w_cnt_next = (w_sync && !w_done) ? r_cnt + CNT_W'(1) : '0;
      end
      PRS:    w_next = w_sync ? PRS : WAIT_R;
      WAIT_R: begin
        w_next     = w_sync ? PRS : w_done ? REL : WAIT_R;
        w_cnt_next = (!w_sync && !w_done) ? r_cnt + CNT_W'(1) : '0;
      end
      default: w_next = REL;
    endcase
  end
  assign w_level = (w_next == PRS) || (w_next == WAIT_R);
  always_comb begin
    w_press   = ((r_state == WAIT_P) && (w_next == PRS)) || w_rpt_fire;
    w_release = (r_state == WAIT_R) && (w_next == REL);
  end
`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
  logic [RPT_W-1:0] r_rpt;
  assign w_rpt_fire = r_level && w_level && (r_rpt == RPT_W'(REPEAT_DELAY - 1));
  // Reloading to DELAY-PERIOD reuses one compare for the first and later repeats.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_rpt <= '0;
    else r_rpt <= !r_level ? '0 : w_rpt_fire ? RPT_W'(REPEAT_DELAY - REPEAT_PERIOD) : r_rpt + RPT_W'(1);
`else
  assign w_rpt_fire = 1'b0;
`endif
  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: N_KEYS independent debounced push-button channels.
// Build with KEY_AUTOREPEAT_EN to add held-key press repetition.
module key_debouncer
  import key_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
  parameter int ACTIVE_LOW      = 1
`ifdef KEY_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY  = KEY_REPEAT_DELAY_DEFAULT
  , parameter int REPEAT_PERIOD = KEY_REPEAT_PERIOD_DEFAULT
`endif
) (
  input logic clk,
  input logic reset_n,
  key_debouncer_if.slave bus
);
  for (genvar k = 0; k < N_KEYS; k++) begin : gen_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW(ACTIVE_LOW)
`ifdef KEY_AUTOREPEAT_EN
      , .REPEAT_DELAY(REPEAT_DELAY)
      , .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_chan (
      .clk(clk),
      .reset_n(reset_n),
      .i_raw(bus.key_raw[k]),
      .o_level(bus.key_level[k]),
      .o_press(bus.key_press[k]),
      .o_release(bus.key_release[k])
    );
  end
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed and random key stimulus against a run-length reference model.
module tb_key_debouncer;
  localparam int N = 2;
  localparam int D = 8;
`ifdef KEY_AUTOREPEAT_EN
  localparam int RD = 20;
  localparam int RP = 6;
  localparam logic [N-1:0] RPT_EXP = 2'b01;
`else
  localparam logic [N-1:0] RPT_EXP = 2'b00;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;
  key_debouncer_if #(.N_KEYS(N)) bus ();
  key_debouncer #(
    .N_KEYS(N),
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW(1)
`ifdef KEY_AUTOREPEAT_EN
    , .REPEAT_DELAY(RD)
    , .REPEAT_PERIOD(RP)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  logic [N-1:0] hist[$];
  int run [N];
  int since [N];
  logic [N-1:0] last_seen, m_level, m_press, m_release;
  logic [N-1:0] rnd_raw;
  int hold [N];
  int errors = 0;
  int checks = 0;
  task automatic model_reset();
    hist.delete();
    last_seen = '0;
    m_level = '0;
    m_press = '0;
    m_release = '0;
    for (int k = 0; k < N; k++) begin
      run[k] = 0;
      since[k] = 0;
    end
  endtask
  // A key is accepted once its synchronised (2-edge delayed) value has differed
  // from the level for D consecutive sampling edges.
  task automatic model_edge(input logic [N-1:0] raw);
    logic [N-1:0] seen;
    hist.push_back(~raw);
    seen = (hist.size() >= 3) ? hist[hist.size()-3] : '0;
    if (hist.size() > 3) void'(hist.pop_front());
    m_press = '0;
    m_release = '0;
    for (int k = 0; k < N; k++) begin
      run[k] = (seen[k] == last_seen[k]) ? run[k] + 1 : 1;
      last_seen[k] = seen[k];
      if (seen[k] != m_level[k] && run[k] >= D) begin
        m_level[k] = seen[k];
        m_press[k] = seen[k];
        m_release[k] = ~seen[k];
        since[k] = 0;
      end else if (m_level[k]) begin
        since[k] = since[k] + 1;
`ifdef KEY_AUTOREPEAT_EN
        if (since[k] == RD || (since[k] > RD && (since[k] - RD) % RP == 0)) m_press[k] = 1'b1;
`endif
      end
    end
  endtask
  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask
  task automatic step(input logic [N-1:0] raw);
    bus.key_raw = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    check("model_level", bus.key_level, m_level);
    check("model_press", bus.key_press, m_press);
    check("model_release", bus.key_release, m_release);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_level"}, bus.key_level, '0);
    check({tag, "_press"}, bus.key_press, '0);
    check({tag, "_release"}, bus.key_release, '0);
  endtask
  task automatic hold_reset(input int cycles);
    reset_n = 1'b0;
    #1;
    check_zero("rst_async");
    repeat (cycles) @(posedge clk);
    #1;
    check_zero("rst_held");
    reset_n = 1'b1;
    model_reset();
  endtask
  initial begin
    bus.key_raw = '1;
    model_reset();
    #2;
    hold_reset(3);
    for (int i = 1; i <= 50; i++) begin
      step(2'b10);
      if (i == 9) check("clean_pre", bus.key_level, 2'b00);
      if (i == 10) begin
        check("clean_level", bus.key_level, 2'b01);
        check("clean_press", bus.key_press, 2'b01);
      end
      if (i == 11) check("clean_once", bus.key_press, 2'b00);
      if (i == 30 || i == 36 || i == 42) check("repeat_press", bus.key_press, RPT_EXP);
      if (i == 29 || i == 31) check("repeat_gap", bus.key_press, 2'b00);
    end
    for (int i = 1; i <= 12; i++) begin
      step(2'b11);
      if (i == 9) check("rel_pre", bus.key_level, 2'b01);
      if (i == 10) begin
        check("rel_level", bus.key_level, 2'b00);
        check("rel_strobe", bus.key_release, 2'b01);
      end
    end
    for (int i = 0; i < 30; i++) begin
      step(((i / 3) % 2 == 0) ? 2'b10 : 2'b11);
      check("bounce_quiet", bus.key_level | bus.key_press, 2'b00);
    end
    for (int i = 1; i <= 12; i++) begin
      step(2'b10);
      if (i == 10) check("bounce_press", bus.key_press, 2'b01);
    end
    repeat (12) step(2'b11);
    for (int i = 1; i <= 19; i++) begin
      step(i <= 7 ? 2'b01 : 2'b11);
      check("glitch_quiet", bus.key_level | bus.key_press | bus.key_release, 2'b00);
    end
    for (int i = 1; i <= 12; i++) begin
      step(2'b00);
      if (i == 10) begin
        check("simul_press", bus.key_press, 2'b11);
        check("simul_level", bus.key_level, 2'b11);
      end
    end
    for (int i = 1; i <= 12; i++) begin
      step(2'b11);
      if (i == 10) check("simul_release", bus.key_release, 2'b11);
    end
    repeat (8) step(2'b10);
    hold_reset(3);
    for (int i = 1; i <= 12; i++) begin
      step(2'b10);
      if (i == 9) check("rst_pre", bus.key_level, 2'b00);
      if (i == 10) check("rst_press", bus.key_press, 2'b01);
    end
    repeat (12) step(2'b11);
    rnd_raw = '1;
    for (int k = 0; k < N; k++) hold[k] = $urandom_range(1, 20);
    repeat (4000) begin
      for (int k = 0; k < N; k++) begin
        hold[k] = hold[k] - 1;
        if (hold[k] == 0) begin
          rnd_raw[k] = ~rnd_raw[k];
          hold[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 14);
        end
      end
      step(rnd_raw);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
